// File: rtl/game_pkg.sv
// Shared game definitions: FSM state codes and default widths.
// The VGA and 7-seg blocks decode game_state through these same codes.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    localparam int SCORE_W_DEFAULT   = 10;
    localparam int OVER_HOLD_DEFAULT = 50;
    localparam int HOLD_W_DEFAULT    = 6;

endpackage

// File: rtl/flap_edge.sv
// Rising-edge detector for the (already debounced) flap button.
// A held button produces a single rise; a release re-arms it.
module flap_edge (
    input  logic clk,
    input  logic clr,
    input  logic flap_btn,
    output logic rise
);

    logic flap_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            flap_q <= 1'b0;
        end else begin
            flap_q <= flap_btn;
        end
    end

    assign rise = flap_btn & ~flap_q;

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game sequencer: FSM, flap command, run/reset gating and scores.
// All outputs are registered, one clock behind the inputs that cause them.
module flappy_game_ctrl
    import game_pkg::*;
#(
    parameter int SCORE_W   = SCORE_W_DEFAULT,
    parameter int OVER_HOLD = OVER_HOLD_DEFAULT,
    parameter int HOLD_W    = HOLD_W_DEFAULT
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               tick,
    input  logic               flap_btn,
    input  logic               pause_sw,
    input  logic               collide,
    input  logic               pillar_passed,
    output logic               game_rst,
    output logic               game_run,
    output logic               flap_pulse,
    output logic [1:0]         game_state,
    output logic [SCORE_W-1:0] current_score,
    output logic [SCORE_W-1:0] highest_score
);

    game_state_e       state;
    game_state_e       next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              rise;
    logic              hold_done;
    logic              score_max;
    logic              round_start;
    logic              over_entry;
    logic              score_inc;
    logic              flap_cmd;
    logic              hold_inc;

    flap_edge u_flap_edge (
        .clk      (clk),
        .clr      (clr),
        .flap_btn (flap_btn),
        .rise     (rise)
    );

    assign hold_done = (hold_cnt == HOLD_W'(OVER_HOLD));
    assign score_max = &current_score;

    always_comb begin
        next_state  = state;
        round_start = 1'b0;
        over_entry  = 1'b0;
        score_inc   = 1'b0;
        flap_cmd    = 1'b0;
        hold_inc    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rise) begin
                    next_state  = ST_PLAY;
                    round_start = 1'b1;
                    flap_cmd    = 1'b1;
                end
            end
            ST_PLAY: begin
                flap_cmd = rise;
                if (collide) begin
                    next_state = ST_OVER;
                    over_entry = 1'b1;
                end else begin
                    score_inc = pillar_passed & ~score_max;
                    if (pause_sw) begin
                        next_state = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (!pause_sw) begin
                    next_state = ST_PLAY;
                end
            end
            ST_OVER: begin
                hold_inc = tick & ~hold_done;
                // Early presses are swallowed until the hold time expires.
                if (rise && hold_done) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state         <= ST_IDLE;
            game_rst      <= 1'b1;
            game_run      <= 1'b0;
            flap_pulse    <= 1'b0;
            current_score <= '0;
            highest_score <= '0;
            hold_cnt      <= '0;
        end else begin
            state      <= next_state;
            game_rst   <= (next_state == ST_IDLE);
            game_run   <= (next_state == ST_PLAY);
            flap_pulse <= flap_cmd;

            if (round_start) begin
                current_score <= '0;
            end else if (score_inc) begin
                current_score <= current_score + 1'b1;
            end

            // Score is not incremented on the collide cycle, so it is final here.
            if (over_entry) begin
                hold_cnt <= '0;
                if (current_score > highest_score) begin
                    highest_score <= current_score;
                end
            end else if (hold_inc) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign game_state = state;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Bench for flappy_game_ctrl: two instances (SCORE_W 10 and 3) checked
// every cycle against a behavioural model, plus hand-computed spot checks.
module tb_flappy_game_ctrl;

    localparam int OH = 50;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic tick = 1'b0;
    logic flap_btn = 1'b0;
    logic pause_sw = 1'b0;
    logic collide = 1'b0;
    logic pillar_passed = 1'b0;

    logic       rst_a, run_a, pulse_a;
    logic [1:0] st_a;
    logic [9:0] cur_a, hi_a;
    logic       rst_b, run_b, pulse_b;
    logic [1:0] st_b;
    logic [2:0] cur_b, hi_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flappy_game_ctrl #(.SCORE_W(10), .OVER_HOLD(OH), .HOLD_W(6)) dut_a (
        .clk(clk), .clr(clr), .tick(tick), .flap_btn(flap_btn),
        .pause_sw(pause_sw), .collide(collide), .pillar_passed(pillar_passed),
        .game_rst(rst_a), .game_run(run_a), .flap_pulse(pulse_a),
        .game_state(st_a), .current_score(cur_a), .highest_score(hi_a)
    );

    flappy_game_ctrl #(.SCORE_W(3), .OVER_HOLD(OH), .HOLD_W(6)) dut_b (
        .clk(clk), .clr(clr), .tick(tick), .flap_btn(flap_btn),
        .pause_sw(pause_sw), .collide(collide), .pillar_passed(pillar_passed),
        .game_rst(rst_b), .game_run(run_b), .flap_pulse(pulse_b),
        .game_state(st_b), .current_score(cur_b), .highest_score(hi_b)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 play, 2 pause, 3 over; index 0 = dut_a, 1 = dut_b.
    int m_mode[2], m_cur[2], m_hi[2], m_hold[2], m_btn[2], m_pulse[2];
    int m_limit[2] = '{1023, 7};
    int pulse_cnt = 0;

    task automatic model_step(input int k);
        bit pressed;
        pressed = flap_btn && !m_btn[k];
        m_btn[k] = flap_btn;
        m_pulse[k] = 0;
        if (clr) begin
            m_mode[k] = 0; m_cur[k] = 0; m_hi[k] = 0;
            m_hold[k] = 0; m_btn[k] = 0;
        end else if (m_mode[k] == 0) begin
            if (pressed) begin
                m_mode[k] = 1; m_cur[k] = 0; m_pulse[k] = 1;
            end
        end else if (m_mode[k] == 1) begin
            m_pulse[k] = pressed;
            if (collide) begin
                if (m_cur[k] > m_hi[k]) m_hi[k] = m_cur[k];
                m_hold[k] = 0;
                m_mode[k] = 3;
            end else begin
                if (pillar_passed && m_cur[k] < m_limit[k]) m_cur[k]++;
                if (pause_sw) m_mode[k] = 2;
            end
        end else if (m_mode[k] == 2) begin
            if (!pause_sw) m_mode[k] = 1;
        end else begin
            if (pressed && m_hold[k] == OH) m_mode[k] = 0;
            else if (tick && m_hold[k] < OH) m_hold[k]++;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        #1;
        check("a_state", st_a, m_mode[0]);
        check("a_rst", rst_a, m_mode[0] == 0);
        check("a_run", run_a, m_mode[0] == 1);
        check("a_pulse", pulse_a, m_pulse[0]);
        check("a_cur", cur_a, m_cur[0]);
        check("a_hi", hi_a, m_hi[0]);
        check("b_state", st_b, m_mode[1]);
        check("b_rst", rst_b, m_mode[1] == 0);
        check("b_run", run_b, m_mode[1] == 1);
        check("b_pulse", pulse_b, m_pulse[1]);
        check("b_cur", cur_b, m_cur[1]);
        check("b_hi", hi_b, m_hi[1]);
        if (pulse_a) pulse_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        flap_btn = 1'b1; cyc(1);
        flap_btn = 1'b0; cyc(1);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1; cyc(1);
            tick = 1'b0; cyc(1);
        end
    endtask

    task automatic passes(input int n);
        repeat (n) begin
            pillar_passed = 1'b1; cyc(1);
            pillar_passed = 1'b0; cyc(1);
        end
    endtask

    initial begin
        // 1: reset, then start a round
        cyc(3);
        clr = 1'b0;
        cyc(1);
        check("t1_state", st_a, 0);
        check("t1_rst", rst_a, 1);
        check("t1_hi", hi_a, 0);
        flap_btn = 1'b1; cyc(1);
        check("t1_play", st_a, 1);
        check("t1_pulse", pulse_a, 1);
        check("t1_rst_low", rst_a, 0);
        flap_btn = 1'b0; cyc(1);
        check("t1_pulse_end", pulse_a, 0);

        // 2: score five pillars, then crash
        passes(5);
        check("t2_cur", cur_a, 5);
        collide = 1'b1; cyc(1);
        collide = 1'b0;
        check("t2_over", st_a, 3);
        check("t2_hi", hi_a, 5);
        check("t2_run", run_a, 0);
        cyc(1);

        // 3: restart hold-off in OVER
        ticks(10);
        press();
        check("t3_early", st_a, 3);
        ticks(45);
        press();
        check("t3_idle", st_a, 0);
        press();
        check("t3_cur", cur_a, 0);
        check("t3_hi", hi_a, 5);

        // 4: pause ignores everything
        passes(2);
        pause_sw = 1'b1; cyc(1);
        check("t4_pause", st_a, 2);
        pillar_passed = 1'b1; flap_btn = 1'b1; collide = 1'b1; cyc(1);
        pillar_passed = 1'b0; flap_btn = 1'b0; collide = 1'b0; cyc(1);
        check("t4_still", st_a, 2);
        check("t4_cur", cur_a, 2);
        pause_sw = 1'b0; cyc(1);
        check("t4_resume", st_a, 1);
        check("t4_cur2", cur_a, 2);

        // 5: collide wins over pillar and pause
        collide = 1'b1; pillar_passed = 1'b1; pause_sw = 1'b1; cyc(1);
        collide = 1'b0; pillar_passed = 1'b0; pause_sw = 1'b0;
        check("t5_over", st_a, 3);
        check("t5_cur", cur_a, 2);
        check("t5_hi", hi_a, 5);
        ticks(50);
        press();
        // pause level in IDLE must not matter
        pause_sw = 1'b1; cyc(3);
        check("t5_idle_pause", st_a, 0);
        pause_sw = 1'b0;
        press();
        check("t5_play", st_a, 1);

        // 6: saturation, held button, reset mid-round
        passes(9);
        check("t6_sat", cur_b, 7);
        check("t6_cur_a", cur_a, 9);
        pulse_cnt = 0;
        flap_btn = 1'b1; cyc(20);
        flap_btn = 1'b0; cyc(1);
        check("t6_pulses", pulse_cnt, 1);
        clr = 1'b1; cyc(1);
        clr = 1'b0; cyc(1);
        check("t6_idle", st_a, 0);
        check("t6_hi_a", hi_a, 0);
        check("t6_hi_b", hi_b, 0);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
